// File: rtl/instr_mem_pkg.sv
// Shared defaults and helpers for the instruction fetch memory.
// The even-parity helper takes a zero-extended word, so it serves any DATA_W up to PAR_MAX_W.
package instr_mem_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int PAR_MAX_W  = 64;

  localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = '0;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH-word storage with one synchronous write port and one registered read port.
// An optional per-word even-parity bit is written on every store and checked on reads.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 64,
  parameter int PAR_EN = 0
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_bad_o
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = DATA_W + ((PAR_EN != 0) ? 1 : 0);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              wr_in_range;
  logic              rd_in_range;

  assign wr_idx      = wr_addr_i[IDX_W-1:0];
  assign rd_idx      = rd_addr_i[IDX_W-1:0];
  assign wr_in_range = 32'(wr_addr_i) < DEPTH;
  assign rd_in_range = 32'(rd_addr_i) < DEPTH;
  assign rd_word     = rd_in_range ? mem_q[rd_idx] : '0;

  // The parity check looks at the addressed word before the read register,
  // so a fault is known in the same cycle the fetch is accepted.
  generate
    if (PAR_EN != 0) begin : g_par
      assign wr_word  = {even_par(PAR_MAX_W'(wr_data_i)), wr_data_i};
      assign rd_bad_o = rd_in_range &&
                        (even_par(PAR_MAX_W'(rd_word[DATA_W-1:0])) != rd_word[DATA_W]);
    end else begin : g_nopar
      assign wr_word  = wr_data_i;
      assign rd_bad_o = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en_i && wr_in_range) begin
      mem_q[wr_idx] <= wr_word;
    end
    if (rd_en_i) begin
      rd_data_q <= rd_word[DATA_W-1:0];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, runtime load port, window faults and a fault counter.
// Define INSTR_FETCH_MEM_PARITY_EN to store and check one even-parity bit per word.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                DEPTH     = 64,
  parameter int                VALID_LIM = 32,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_WORD_DEF),
  parameter int                FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [FCNT_W-1:0] fault_cnt,
  output logic              par_err
);

`ifdef INSTR_FETCH_MEM_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic              rsp_arr_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;
  logic              par_err_q;

  logic              accept;
  logic              in_win;
  logic              arr_bad;
  logic              fault_d;
  logic [DATA_W-1:0] arr_rdata;

  // Loads take priority over fetches; a held response also blocks new requests.
  assign req_ready = !ld_en && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign in_win    = 32'(req_addr) < VALID_LIM;
  assign fault_d   = !in_win || arr_bad;
  assign fcnt_d    = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;

  instr_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PAR_EN (PAR_EN)
  ) u_arr (
    .clk       (clk),
    .wr_en_i   (ld_en),
    .wr_addr_i (ld_addr),
    .wr_data_i (ld_data),
    .rd_en_i   (accept && in_win),
    .rd_addr_i (req_addr),
    .rd_data_o (arr_rdata),
    .rd_bad_o  (arr_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_arr_q   <= 1'b0;
      fcnt_q      <= '0;
      par_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_fault_q <= fault_d;
      rsp_arr_q   <= !fault_d;
      if (fault_d) begin
        fcnt_q <= fcnt_d;
      end
      if (in_win && arr_bad) begin
        par_err_q <= 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // The array output is not reset, so the response mux reads zero until a good fetch lands.
  assign rsp_instr = rsp_arr_q   ? arr_rdata :
                     rsp_fault_q ? NOP_WORD  : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign fault_cnt = fcnt_q;
  assign par_err   = par_err_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic [7:0]  fault_cnt;
  logic        par_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .fault_cnt (fault_cnt),
    .par_err   (par_err)
  );

  typedef struct {
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    logic        req_valid;
    logic [5:0]  req_addr;
    logic        rsp_ready;
    logic        e_ready;
    logic        e_valid;
    logic        chk_rsp;
    logic [31:0] e_instr;
    logic        e_fault;
    logic [7:0]  e_cnt;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 6'd31, 32'h0000_0077, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0, "ld31"};
    vecs[1]  = '{1'b1, 6'd0,  32'h0000_0020, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0, "ld0"};
    vecs[2]  = '{1'b1, 6'd5,  32'h0000_0031, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0, "ld5"};
    vecs[3]  = '{1'b0, 6'd0,  32'h0,         1'b1, 6'd0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b0, 8'd0, "fetch0"};
    vecs[4]  = '{1'b0, 6'd0,  32'h0,         1'b1, 6'd5,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0031, 1'b0, 8'd0, "fetch5"};
    vecs[5]  = '{1'b0, 6'd0,  32'h0,         1'b1, 6'd40, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 8'd1, "fetch40"};
    vecs[6]  = '{1'b0, 6'd0,  32'h0,         1'b1, 6'd31, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0077, 1'b0, 8'd1, "fetch31"};
    vecs[7]  = '{1'b0, 6'd0,  32'h0,         1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 8'd1, "idle"};
    vecs[8]  = '{1'b1, 6'd3,  32'hDEAD_BEEF, 1'b1, 6'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'd1, "ldstall"};
    vecs[9]  = '{1'b0, 6'd0,  32'h0,         1'b1, 6'd3,  1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'd1, "fetch3"};
    vecs[10] = '{1'b0, 6'd0,  32'h0,         1'b1, 6'd63, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 8'd2, "fetch63"};
    vecs[11] = '{1'b0, 6'd0,  32'h0,         1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 8'd2, "idle2"};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_instr", rsp_instr, 32'h0);
    check("rst_fault", 32'(rsp_fault), 32'd0);
    check("rst_cnt", 32'(fault_cnt), 32'd0);
    check("rst_par", 32'(par_err), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      ld_en     = vecs[i].ld_en;
      ld_addr   = vecs[i].ld_addr;
      ld_data   = vecs[i].ld_data;
      req_valid = vecs[i].req_valid;
      req_addr  = vecs[i].req_addr;
      rsp_ready = vecs[i].rsp_ready;
      #1;
      check({vecs[i].name, "_ready"}, 32'(req_ready), 32'(vecs[i].e_ready));
      tick();
      check({vecs[i].name, "_valid"}, 32'(rsp_valid), 32'(vecs[i].e_valid));
      check({vecs[i].name, "_cnt"}, 32'(fault_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_rsp) begin
        check({vecs[i].name, "_instr"}, rsp_instr, vecs[i].e_instr);
        check({vecs[i].name, "_fault"}, 32'(rsp_fault), 32'(vecs[i].e_fault));
      end
    end
    idle_inputs();

    // Backpressure: hold the response of addr 5 for three cycles, with a load to addr 7 mid-hold.
    req_valid = 1'b1;
    req_addr  = 6'd5;
    tick();
    check("bp_first", rsp_instr, 32'h0000_0031);
    req_addr  = 6'd0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_en   = (k == 1);
      ld_addr = 6'd7;
      ld_data = 32'h0000_0099;
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_instr", rsp_instr, 32'h0000_0031);
    end
    ld_en     = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    req_addr = 6'd7;
    tick();
    check("bp_release_instr", rsp_instr, 32'h0000_0099);
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    tick();
    check("bp_drain_valid", 32'(rsp_valid), 32'd0);

    // Asynchronous reset while a response is outstanding.
    req_valid = 1'b1;
    req_addr  = 6'd5;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check("mid_valid_before", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_instr", rsp_instr, 32'h0);
    check("mid_rst_cnt", 32'(fault_cnt), 32'd0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 6'd5;
    tick();
    check("retain_instr", rsp_instr, 32'h0000_0031);
    check("retain_fault", 32'(rsp_fault), 32'd0);

    // Fault counter saturation over 300 back-to-back window faults.
    req_addr = 6'd40;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 254) check("sat_254", 32'(fault_cnt), 32'h0000_00FE);
      if (n == 255) check("sat_255", 32'(fault_cnt), 32'h0000_00FF);
    end
    check("sat_300", 32'(fault_cnt), 32'h0000_00FF);
    check("sat_fault", 32'(rsp_fault), 32'd1);
    check("sat_instr", rsp_instr, 32'h0);
    req_valid = 1'b0;
    tick();

`ifdef INSTR_FETCH_MEM_PARITY_EN
    dut.u_arr.mem_q[5][0] = ~dut.u_arr.mem_q[5][0];
    req_valid = 1'b1;
    req_addr  = 6'd5;
    tick();
    check("par_fault", 32'(rsp_fault), 32'd1);
    check("par_instr", rsp_instr, 32'h0);
    check("par_err", 32'(par_err), 32'd1);
    req_addr = 6'd0;
    tick();
    check("par_good_fault", 32'(rsp_fault), 32'd0);
    check("par_good_instr", rsp_instr, 32'h0000_0020);
    check("par_sticky", 32'(par_err), 32'd1);
    req_valid = 1'b0;
    tick();
`else
    check("par_err_tied", 32'(par_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
